// File: rtl/feature_stream_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : feature_stream_framer_pkg
// Description : Shared types and constants for the feature stream framer:
//               FSM state encoding, skid-entry layout, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package feature_stream_framer_pkg;

    localparam int DATA_W_DEF = 8;   // matches FIFO read data width
    localparam int COL_W_DEF  = 10;
    localparam int ROW_W_DEF  = 10;
    localparam int FLAG_W     = 3;   // sof, eol, eof

    // FSM state encoding (explicit 2-bit width for legacy tooling)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_FLUSH  = 2'd2;

    // Layout of one skid-buffer entry; the flat payload in the framer uses
    // the same bit order: {data, sof, eol, eof}.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  sof;
        logic                  eol;
        logic                  eof;
    } skid_entry_t;

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_buf
// Description : 2-entry valid/ready register buffer. Entry 0 drives the
//               output directly; entry 1 holds a beat that arrived while the
//               output was stalled. free_next reports whether at least one
//               entry will be free after the current edge, so the producer can
//               register its enable without risking overflow.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_data   - push side (no ready; producer honours
//                                    free_next)
//               out_valid/out_data/out_ready - pop side
//               free_next          - occupancy after this edge is < 2
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buf
    import feature_stream_framer_pkg::*;
#(
    parameter int PAYLOAD_W = DATA_W_DEF + FLAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 out_ready,
    output logic                 free_next
);

    logic [1:0]           cnt_q,  cnt_d;
    logic [PAYLOAD_W-1:0] e0_q,   e0_d;
    logic [PAYLOAD_W-1:0] e1_q,   e1_d;
    logic                 pop;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = e0_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case (cnt_q)
            2'd0: begin
                if (in_valid) begin
                    e0_d  = in_data;
                    cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (in_valid && pop) begin
                    e0_d = in_data;
                end else if (in_valid) begin
                    e1_d  = in_data;
                    cnt_d = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    e0_d = e1_q;
                    if (in_valid) begin
                        e1_d = in_data;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    assign free_next = (cnt_d != 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/feature_stream_framer.sv
`default_nettype none
// ============================================================================
// Module      : feature_stream_framer
// Description : Pops samples from a show-ahead FIFO, counts them into a
//               cols x rows frame and re-emits them on a valid/ready stream
//               tagged with sof/eol/eof through a 2-entry skid buffer.
// Ports       : rd_clk, rd_rst (async, active-high)
//               start, cfg_cols_m1, cfg_rows_m1 - frame request and size
//               fifo_data, fifo_vld, fifo_rd_en - FIFO pop handshake
//               m_data, m_valid, m_ready, m_sof, m_eol, m_eof - output stream
//               busy, done - frame status
// Revision    : 1.0 - initial release
// ============================================================================
module feature_stream_framer
    import feature_stream_framer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COL_W  = COL_W_DEF,
    parameter int ROW_W  = ROW_W_DEF
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              start,
    input  logic [COL_W-1:0]  cfg_cols_m1,
    input  logic [ROW_W-1:0]  cfg_rows_m1,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_vld,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic              done
);

    localparam int PAYLOAD_W = DATA_W + FLAG_W;

    state_t            state_q,   state_d;
    logic [COL_W-1:0]  col_q,     col_d;
    logic [ROW_W-1:0]  row_q,     row_d;
    logic [COL_W-1:0]  cols_m1_q, cols_m1_d;
    logic [ROW_W-1:0]  rows_m1_q, rows_m1_d;
    logic              rd_en_q,   rd_en_d;
    logic              done_q,    done_d;

    logic                 xfer;
    logic                 sof_w, eol_w, eof_w;
    logic                 free_next;
    logic [PAYLOAD_W-1:0] push_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    assign xfer  = fifo_vld && rd_en_q;
    assign sof_w = (col_q == '0) && (row_q == '0);
    assign eol_w = (col_q == cols_m1_q);
    assign eof_w = eol_w && (row_q == rows_m1_q);

    assign push_payload = {fifo_data, sof_w, eol_w, eof_w};

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        cols_m1_d = cols_m1_q;
        rows_m1_d = rows_m1_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cols_m1_d = cfg_cols_m1;
                    rows_m1_d = cfg_rows_m1;
                    col_d     = '0;
                    row_d     = '0;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    if (eol_w) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (eof_w) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (m_valid && m_ready && m_eof) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered pop enable looks at next-cycle state and occupancy, so
        // it drops the cycle after the eof pop and never overfills the skid.
        rd_en_d = (state_d == ST_STREAM) && free_next;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            cols_m1_q <= '0;
            rows_m1_q <= '0;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            cols_m1_q <= cols_m1_d;
            rows_m1_q <= rows_m1_d;
            rd_en_q   <= rd_en_d;
            done_q    <= done_d;
        end
    end

    stream_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .in_valid  (xfer),
        .in_data   (push_payload),
        .out_valid (m_valid),
        .out_data  (out_payload),
        .out_ready (m_ready),
        .free_next (free_next)
    );

    assign m_data     = out_payload[PAYLOAD_W-1:FLAG_W];
    assign m_sof      = out_payload[2];
    assign m_eol      = out_payload[1];
    assign m_eof      = out_payload[0];
    assign fifo_rd_en = rd_en_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_feature_stream_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_feature_stream_framer
// Description : Directed self-checking bench for feature_stream_framer with a
//               show-ahead FIFO model and a cycle-stepped stimulus engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_feature_stream_framer;

    logic       rd_clk = 1'b0;
    logic       rd_rst;
    logic       start;
    logic [9:0] cfg_cols_m1;
    logic [9:0] cfg_rows_m1;
    logic [7:0] fifo_data;
    logic       fifo_vld;
    logic       fifo_rd_en;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_sof, m_eol, m_eof;
    logic       busy, done;

    feature_stream_framer dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .start       (start),
        .cfg_cols_m1 (cfg_cols_m1),
        .cfg_rows_m1 (cfg_rows_m1),
        .fifo_data   (fifo_data),
        .fifo_vld    (fifo_vld),
        .fifo_rd_en  (fifo_rd_en),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sof       (m_sof),
        .m_eol       (m_eol),
        .m_eof       (m_eof),
        .busy        (busy),
        .done        (done)
    );

    always #5 rd_clk = ~rd_clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  fifo_q[$];
    logic [10:0] got[$];
    int          beat_cyc[$];
    int cyc = 0;
    int vld_period = 1;
    int ready_mode = 0;
    int start_at = -1, start_at2 = -1;
    logic [9:0] s_cols, s_rows, s2_cols, s2_rows;
    int pops, done_cnt, done_cyc, stall_err, max_occ;
    logic        prev_stall;
    logic [10:0] prev_word;

    function automatic logic [10:0] exp_word(logic [7:0] d, int idx, int cols, int total);
        return {d, idx == 0, (idx % cols) == cols - 1, idx == total - 1};
    endfunction

    task automatic drive_inputs();
        fifo_vld  = (fifo_q.size() > 0) && (cyc % vld_period == 0);
        fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        m_ready   = (ready_mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
        start     = (cyc == start_at) || (cyc == start_at2);
        if (cyc == start_at) begin
            cfg_cols_m1 = s_cols;
            cfg_rows_m1 = s_rows;
        end else if (cyc == start_at2) begin
            cfg_cols_m1 = s2_cols;
            cfg_rows_m1 = s2_rows;
        end
    endtask

    task automatic clear_run();
        got.delete();
        beat_cyc.delete();
        pops = 0; done_cnt = 0; done_cyc = -1; stall_err = 0; max_occ = 0;
        prev_stall = 1'b0; prev_word = '0;
        start_at = -1; start_at2 = -1; vld_period = 1; ready_mode = 0;
    endtask

    task automatic load_fifo(int first, int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(8'(first + i));
        drive_inputs();
    endtask

    // Observe at negedge, advance FIFO model and stimulus just after posedge.
    task automatic run_cycles(int n);
        logic [10:0] w;
        logic        popped;
        for (int i = 0; i < n; i++) begin
            @(negedge rd_clk);
            w = {m_data, m_sof, m_eol, m_eof};
            if (prev_stall && (w !== prev_word)) stall_err++;
            prev_stall = m_valid && !m_ready;
            prev_word  = w;
            if (m_valid && m_ready) begin
                got.push_back(w);
                beat_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            popped = fifo_vld && fifo_rd_en;
            if (popped) pops++;
            if (pops - got.size() > max_occ) max_occ = pops - got.size();
            @(posedge rd_clk);
            #1;
            if (popped) void'(fifo_q.pop_front());
            cyc++;
            drive_inputs();
        end
    endtask

    task automatic test_reset();
        rd_rst = 1'b1;
        start = 1'b0; cfg_cols_m1 = '0; cfg_rows_m1 = '0;
        fifo_data = '0; fifo_vld = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge rd_clk);
        #1;
        vectors++;
        if ({fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof, busy, done} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof, busy, done});
        end
        rd_rst = 1'b0;
        clear_run();
        load_fifo(8'h40, 4);
        run_cycles(4);
        vectors++;
        if (pops !== 0) begin
            miscompares++;
            $display("FAIL idle_no_pop got=%0d exp=0", pops);
        end
    endtask

    task automatic test_basic();
        int s;
        clear_run();
        load_fifo(0, 10);
        s = cyc + 1; start_at = s; s_cols = 10'd3; s_rows = 10'd1;
        run_cycles(16);
        vectors++;
        if (got.size() !== 8) begin
            miscompares++;
            $display("FAIL basic_count got=%0d exp=8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            vectors++;
            if (got[i] !== exp_word(8'(i), i, 4, 8)) begin
                miscompares++;
                $display("FAIL basic_beat%0d got=%h exp=%h", i, got[i], exp_word(8'(i), i, 4, 8));
            end
        end
        if (got.size() == 8) begin
            vectors++;
            if (beat_cyc[0] !== s + 2 || beat_cyc[7] !== s + 9) begin
                miscompares++;
                $display("FAIL basic_timing got=%0d,%0d exp=%0d,%0d",
                         beat_cyc[0] - s, beat_cyc[7] - s, 2, 9);
            end
        end
        vectors++;
        if (done_cnt !== 1 || done_cyc !== s + 10) begin
            miscompares++;
            $display("FAIL basic_done got=%0d@%0d exp=1@%0d", done_cnt, done_cyc - s, 10);
        end
        vectors++;
        if (pops !== 8 || fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_after got=pops%0d/rd%b/busy%b exp=pops8/rd0/busy0",
                     pops, fifo_rd_en, busy);
        end
    endtask

    task automatic test_backpressure();
        clear_run();
        load_fifo(0, 10);
        ready_mode = 1;
        start_at = cyc + 1; s_cols = 10'd3; s_rows = 10'd1;
        run_cycles(40);
        vectors++;
        if (got.size() !== 8) begin
            miscompares++;
            $display("FAIL bp_count got=%0d exp=8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            vectors++;
            if (got[i] !== exp_word(8'(i), i, 4, 8)) begin
                miscompares++;
                $display("FAIL bp_beat%0d got=%h exp=%h", i, got[i], exp_word(8'(i), i, 4, 8));
            end
        end
        vectors++;
        if (stall_err !== 0 || max_occ > 2) begin
            miscompares++;
            $display("FAIL bp_stall got=unstable%0d/occ%0d exp=0/<=2", stall_err, max_occ);
        end
        vectors++;
        if (done_cnt !== 1 || pops !== 8) begin
            miscompares++;
            $display("FAIL bp_done got=%0d/%0d exp=1/8", done_cnt, pops);
        end
    endtask

    task automatic test_vld_gaps();
        clear_run();
        load_fifo(8'h10, 10);
        vld_period = 3;
        start_at = cyc + 1; s_cols = 10'd3; s_rows = 10'd1;
        run_cycles(45);
        vectors++;
        if (got.size() !== 8) begin
            miscompares++;
            $display("FAIL gap_count got=%0d exp=8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            vectors++;
            if (got[i] !== exp_word(8'(8'h10 + i), i, 4, 8)) begin
                miscompares++;
                $display("FAIL gap_beat%0d got=%h exp=%h", i, got[i],
                         exp_word(8'(8'h10 + i), i, 4, 8));
            end
        end
        if (got.size() == 8) begin
            vectors++;
            if (beat_cyc[7] - beat_cyc[0] !== 21) begin
                miscompares++;
                $display("FAIL gap_spacing got=%0d exp=21", beat_cyc[7] - beat_cyc[0]);
            end
        end
        vectors++;
        if (done_cnt !== 1 || pops !== 8) begin
            miscompares++;
            $display("FAIL gap_done got=%0d/%0d exp=1/8", done_cnt, pops);
        end
    endtask

    task automatic test_single();
        int s;
        clear_run();
        fifo_q.delete();
        fifo_q.push_back(8'hA5); fifo_q.push_back(8'h5A); fifo_q.push_back(8'h3C);
        drive_inputs();
        s = cyc + 1; start_at = s; s_cols = 10'd0; s_rows = 10'd0;
        run_cycles(10);
        vectors++;
        if (got.size() !== 1 || got[0] !== {8'hA5, 3'b111}) begin
            miscompares++;
            $display("FAIL single_beat got=%0d/%h exp=1/%h", got.size(),
                     (got.size() > 0) ? got[0] : 11'h0, {8'hA5, 3'b111});
        end
        vectors++;
        if (done_cnt !== 1 || done_cyc !== s + 3) begin
            miscompares++;
            $display("FAIL single_done got=%0d@%0d exp=1@3", done_cnt, done_cyc - s);
        end
        vectors++;
        if (pops !== 1 || fifo_q.size() !== 2) begin
            miscompares++;
            $display("FAIL single_pops got=%0d exp=1", pops);
        end
    endtask

    task automatic test_start_ignored();
        int s;
        clear_run();
        load_fifo(8'h20, 12);
        s = cyc + 1; start_at = s; s_cols = 10'd3; s_rows = 10'd1;
        start_at2 = s + 4; s2_cols = 10'd0; s2_rows = 10'd0;
        run_cycles(20);
        vectors++;
        if (got.size() !== 8) begin
            miscompares++;
            $display("FAIL ign_count got=%0d exp=8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            vectors++;
            if (got[i] !== exp_word(8'(8'h20 + i), i, 4, 8)) begin
                miscompares++;
                $display("FAIL ign_beat%0d got=%h exp=%h", i, got[i],
                         exp_word(8'(8'h20 + i), i, 4, 8));
            end
        end
        vectors++;
        if (done_cnt !== 1 || pops !== 8) begin
            miscompares++;
            $display("FAIL ign_done got=%0d/%0d exp=1/8", done_cnt, pops);
        end
    endtask

    task automatic test_midframe_reset();
        clear_run();
        load_fifo(0, 16);
        start_at = cyc + 1; s_cols = 10'd3; s_rows = 10'd3;
        run_cycles(7);
        vectors++;
        if (got.size() !== 4 || pops !== 5) begin
            miscompares++;
            $display("FAIL mr_progress got=%0d/%0d exp=4/5", got.size(), pops);
        end
        rd_rst = 1'b1;
        #1;
        vectors++;
        if ({fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof, busy, done} !== 15'd0) begin
            miscompares++;
            $display("FAIL mr_outputs got=%h exp=0",
                     {fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof, busy, done});
        end
        run_cycles(2);
        rd_rst = 1'b0;
        run_cycles(2);
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL mr_no_done got=%0d exp=0", done_cnt);
        end
        clear_run();
        start_at = cyc + 1; s_cols = 10'd0; s_rows = 10'd0;
        drive_inputs();
        run_cycles(10);
        vectors++;
        if (got.size() !== 1 || got[0] !== {8'd5, 3'b111} || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL mr_restart got=%0d/%h/%0d exp=1/%h/1", got.size(),
                     (got.size() > 0) ? got[0] : 11'h0, done_cnt, {8'd5, 3'b111});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_vld_gaps();
        test_single();
        test_start_ignored();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
